// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and constants for the parking-lot display
package parking_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } slot_state_e;

  localparam int CNT_W     = 5;
  localparam int SLOTS_DEF = 8;

  // Ceiling log2, floored at 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - blink prescaler and global phase for the parking LEDs
module blink_timer
  import parking_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic power,
  output logic tick,
  output logic phase
);

  localparam int PW = clog2(BLINK_DIV);
  localparam logic [PW-1:0] LAST = PW'(BLINK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign tick  = power & (cnt_q == LAST);
  assign phase = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!power) begin
      // Powered down: park so every restart blinks from the same point.
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/parking_led_ctrl.sv
// rtl/parking_led_ctrl.sv - per-space LED driver with departure flash sequence
module parking_led_ctrl
  import parking_pkg::*;
#(
  parameter int SLOTS       = SLOTS_DEF,
  parameter int BLINK_DIV   = 25_000_000,
  parameter int BLINK_COUNT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               power,
  input  logic [SLOTS-1:0]   occupied,
  input  logic [SLOTS-1:0]   leave_req,
  output logic [2*SLOTS-1:0] led,
  output logic [SLOTS-1:0]   leaving,
  output logic [SLOTS-1:0]   leave_done,
  output logic               lot_full
);

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(2 * BLINK_COUNT - 1);

  logic tick;
  logic phase;
  logic lot_full_q, lot_full_d;

  blink_timer #(
    .BLINK_DIV(BLINK_DIV)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .power(power),
    .tick (tick),
    .phase(phase)
  );

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    slot_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             led_occ_q, led_occ_d;
    logic             led_free_q, led_free_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (power && leave_req[i] && occupied[i]) begin
            state_d = FLASH;
            cnt_d   = '0;
          end
        end
        FLASH: begin
          // Abort is checked first so it beats a coincident final tick.
          if (!power || !occupied[i]) begin
            state_d = IDLE;
          end else if (tick) begin
            if (cnt_q == LAST_TICK) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      led_occ_d  = power & occupied[i] & ((state_q == IDLE) | phase);
      led_free_d = power & ~occupied[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        done_q     <= 1'b0;
        led_occ_q  <= 1'b0;
        led_free_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        done_q     <= done_d;
        led_occ_q  <= led_occ_d;
        led_free_q <= led_free_d;
      end
    end

    assign leaving[i]    = (state_q == FLASH);
    assign leave_done[i] = done_q;
    assign led[2*i+1]    = led_occ_q;
    assign led[2*i]      = led_free_q;
  end

  assign lot_full_d = power & (&occupied);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lot_full_q <= 1'b0;
    else        lot_full_q <= lot_full_d;
  end

  assign lot_full = lot_full_q;

endmodule

// File: tb/tb_parking_led_ctrl.sv
// tb/tb_parking_led_ctrl.sv - directed self-checking bench for parking_led_ctrl
module tb_parking_led_ctrl;

  localparam int SLOTS       = 4;
  localparam int BLINK_DIV   = 4;
  localparam int BLINK_COUNT = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               power = 1'b0;
  logic [SLOTS-1:0]   occupied = '0;
  logic [SLOTS-1:0]   leave_req = '0;
  logic [2*SLOTS-1:0] led;
  logic [SLOTS-1:0]   leaving;
  logic [SLOTS-1:0]   leave_done;
  logic               lot_full;

  int n_cmp  = 0;
  int n_fail = 0;

  parking_led_ctrl #(
    .SLOTS      (SLOTS),
    .BLINK_DIV  (BLINK_DIV),
    .BLINK_COUNT(BLINK_COUNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .power     (power),
    .occupied  (occupied),
    .leave_req (leave_req),
    .led       (led),
    .leaving   (leaving),
    .leave_done(leave_done),
    .lot_full  (lot_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reset is released on a negedge; that negedge is cycle N0 of each scenario.
  task automatic do_reset(input logic [SLOTS-1:0] occ);
    rst_n     = 1'b0;
    power     = 1'b1;
    occupied  = occ;
    leave_req = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_flash(input bit repulse, input string tag);
    int lcnt;
    int dcnt;
    int dpos;
    lcnt = 0;
    dcnt = 0;
    dpos = -1;
    do_reset(4'b0001);
    step();
    step();
    step();
    leave_req = 4'b0001;  // N3: coincides with the tick, so that tick is not counted
    step();
    for (int k = 4; k <= 22; k++) begin
      if (leaving[0]) lcnt++;
      if (leave_done[0]) begin
        dcnt++;
        dpos = k;
      end
      if (k == 6)  check({tag, "_led1_n6"},  32'(led[1]), 32'd0);
      if (k == 10) check({tag, "_led1_n10"}, 32'(led[1]), 32'd1);
      if (k == 14) check({tag, "_led1_n14"}, 32'(led[1]), 32'd0);
      if (k == 18) check({tag, "_led1_n18"}, 32'(led[1]), 32'd1);
      if (k == 22) check({tag, "_led1_after"}, 32'(led[1]), 32'd1);
      leave_req = (repulse && k == 10) ? 4'b0001 : 4'b0000;
      step();
    end
    check({tag, "_leaving_cycles"}, 32'(lcnt), 32'd16);
    check({tag, "_done_pulses"}, 32'(dcnt), 32'd1);
    check({tag, "_done_pos"}, 32'(dpos), 32'd20);
  endtask

  initial begin
    bit bad;

    // 1. reset / idle
    rst_n = 1'b0;
    power = 1'b1;
    occupied = 4'b0101;
    #3;
    check("rst_led", 32'(led), 32'h0);
    check("rst_leaving", 32'(leaving), 32'h0);
    check("rst_done", 32'(leave_done), 32'h0);
    check("rst_lot_full", 32'(lot_full), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_led", 32'(led), 32'(8'b01_10_01_10));
    check("idle_lot_full", 32'(lot_full), 32'd0);
    occupied = 4'b1111;
    step();
    check("full_lot_full", 32'(lot_full), 32'd1);
    check("full_led", 32'(led), 32'(8'b10_10_10_10));

    // 2. full flash sequence
    run_flash(1'b0, "flash");

    // 3. abort on slot 2
    do_reset(4'b0100);
    leave_req = 4'b0100;
    step();
    leave_req = '0;
    check("abort_enter", 32'(leaving[2]), 32'd1);
    step();
    step();
    step();
    check("abort_still", 32'(leaving[2]), 32'd1);
    occupied = 4'b0000;
    step();
    check("abort_leaving", 32'(leaving[2]), 32'd0);
    check("abort_led5", 32'(led[5]), 32'd0);
    check("abort_led4", 32'(led[4]), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (leave_done !== 4'b0000) bad = 1'b1;
      step();
    end
    check("abort_no_done", 32'(bad), 32'd0);

    // 4a. request on an empty space
    do_reset(4'b0000);
    leave_req = 4'b1000;
    step();
    leave_req = '0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (leaving !== 4'b0000) bad = 1'b1;
      step();
    end
    check("empty_req_ignored", 32'(bad), 32'd0);

    // 4b. re-request mid-flash does not extend
    run_flash(1'b1, "repulse");

    // 5. power drop with two slots flashing
    do_reset(4'b0011);
    leave_req = 4'b0011;
    step();
    leave_req = '0;
    check("pwr_two_flash", 32'(leaving), 32'(4'b0011));
    step();
    power = 1'b0;
    step();
    check("pwr_led", 32'(led), 32'h0);
    check("pwr_leaving", 32'(leaving), 32'h0);
    check("pwr_done", 32'(leave_done), 32'h0);
    check("pwr_lot_full", 32'(lot_full), 32'd0);
    power = 1'b1;
    step();
    check("pwr_back_led", 32'(led), 32'(8'b01_01_10_10));
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (led !== 8'b01_01_10_10 || leaving !== 4'b0000 || leave_done !== 4'b0000) bad = 1'b1;
      step();
    end
    check("pwr_back_steady", 32'(bad), 32'd0);

    // 6. asynchronous reset mid-flash
    do_reset(4'b0001);
    leave_req = 4'b0001;
    step();
    leave_req = '0;
    step();
    step();
    step();
    step();
    check("async_pre", 32'(leaving[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_leaving", 32'(leaving), 32'h0);
    check("async_led", 32'(led), 32'h0);
    step();
    rst_n = 1'b1;
    check("async_phase", 32'(dut.u_timer.phase_q), 32'd1);
    step();
    check("async_led_after", 32'(led), 32'(8'b01_01_01_10));
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (leaving !== 4'b0000 || led[1] !== 1'b1) bad = 1'b1;
      step();
    end
    check("async_idle_after", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parking_led_ctrl.md
Name: parking_led_ctrl

Overview:
Registered LED driver for the parking-lot display, generalised to SLOTS spaces. Each space drives a red/occupied LED and a green/free LED. The block generates its own blink timebase. A departing car's LED flashes a fixed number of times, then the block reports completion. It sits between the slot-status logic (switches, leave requests) and the board LED pins.

Parameters:
SLOTS, 8, number of parking spaces (1..32)
BLINK_DIV, 25_000_000, clock cycles per blink half-period (>=2)
BLINK_COUNT, 3, number of full on/off flashes for a departing car (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
power  in  1  system enable; low blanks the display and aborts all activity
occupied  in  SLOTS  space i currently holds a car (switch state)
leave_req  in  SLOTS  single-cycle request: car in space i starts leaving
led  out  2*SLOTS  led[2i+1]=occupied LED of space i, led[2i]=free LED of space i
leaving  out  SLOTS  space i is in its flashing sequence
leave_done  out  SLOTS  one-cycle pulse when space i completes its sequence
lot_full  out  1  power high and every space occupied

Behaviour:
- Clock and reset: one clock domain; rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: led=0, leaving=0, leave_done=0, lot_full=0, prescaler=0, phase=1, all slot FSMs IDLE.
- Prescaler:
  - Counts 0..BLINK_DIV-1 while power=1.
  - tick=1 on the cycle the count equals BLINK_DIV-1; the count then wraps to 0 and phase toggles.
  - With power=0, the prescaler is held at 0 and phase at 1.
  - Phase is global, so all flashing spaces blink in sync.
- Per-slot FSM, states IDLE and FLASH, with a 5-bit tick counter cnt:
  - IDLE->FLASH when power & leave_req[i] & occupied[i]. cnt is cleared to 0.
  - In FLASH, cnt increments on each tick.
  - FLASH->IDLE when tick occurs with cnt==2*BLINK_COUNT-1. leave_done[i] pulses in the cycle after the transition edge, i.e. coincident with leaving[i] falling.
  - FLASH->IDLE abort, with no leave_done, when occupied[i]=0 or power=0.
  - A leave_req while in FLASH is ignored; the sequence is not restarted.
  - A leave_req on an unoccupied space is ignored.
  - The first flash is shortened because the phase is global. Total FLASH duration is between (2*BLINK_COUNT-1)*BLINK_DIV+1 and 2*BLINK_COUNT*BLINK_DIV cycles.
- LED equations, registered with 1-cycle latency from inputs/state:
  - power=0: all LEDs 0.
  - led[2i+1] = occupied[i] & (state==IDLE | phase).
  - led[2i] = ~occupied[i].
  - lot_full = power & (&occupied).
- Completion: after leave_done the slot stays IDLE. The occupied LED remains lit until occupied[i] falls, since the switch is the authority on occupancy.
- Simultaneous events:
  - Requests on several slots in the same cycle are all accepted independently.
  - leave_req coincident with tick: the slot enters FLASH and that tick is not counted.
  - occupied falling on the same cycle as the final tick: abort wins, so no leave_done.
- Mid-operation reset: asserting rst_n=0 immediately forces the reset values regardless of state.

Decomposition:
- Package parking_pkg holds:
  - slot_state_e (IDLE, FLASH)
  - CNT_W=5
  - function clog2 for the prescaler width
  - shared SLOTS default, also used by the parking-lot top-level
- Sub-module blink_timer contains the prescaler plus phase register, outputs tick and phase, parameter BLINK_DIV.
- Per-slot FSMs are a generate loop inside parking_led_ctrl.

Test Plan:
All scenarios use SLOTS=4, BLINK_DIV=4, BLINK_COUNT=2.
1. Reset/idle: rst_n=0 then release with power=1, occupied=4'b0101. One cycle later led=8'b01_10_01_10 and lot_full=0. Setting occupied=4'b1111 gives lot_full=1 in the next cycle.
2. Full flash: occupied=4'b0001, leave_req[0] pulse, aligned so the next tick is 4 cycles later.
   - leaving[0]=1 for 16 cycles (4 ticks).
   - led[1] toggles on each tick after the request: 0,1,0,1 pattern.
   - leave_done[0] is a single 1-cycle pulse as leaving[0] falls.
   - led[1]=1 afterwards.
3. Abort: during FLASH on slot 2, drop occupied[2]. Next cycle leaving[2]=0, no leave_done pulse, led[5]=0, led[4]=1.
4. Ignored requests:
   - leave_req[3] with occupied[3]=0 gives no leaving.
   - Re-pulsing leave_req[0] mid-FLASH does not extend the sequence; still 4 ticks total.
5. Power drop: while two slots are flashing, power=0. Next cycle led=0, leaving=0, no leave_done. After power=1, led follows occupied with no flashing.
6. Async reset mid-FLASH: pulse rst_n low between clock edges. Outputs clear immediately, without waiting for a clock edge. After release the state is IDLE and phase=1.
